// File: rtl/cosim_vector_driver.sv
`default_nettype none
// ============================================================================
// Module   : cosim_vector_driver
// Purpose  : LFSR stimulus generator with settle delay, valid/ready response
//            stream and MISR signature over accepted DUT samples.
// Revision : 1.0
// ============================================================================
module cosim_vector_driver #(
  parameter logic [127:0] SEED   = 128'h1,
  parameter int           SETTLE = 1,
  parameter int           NVEC   = 256
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [127:0] vec_out,
  input  logic [127:0] dut_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic [15:0]  res_index,
  output logic [127:0] signature
);

  localparam logic [1:0]   C_IDLE     = 2'd0;
  localparam logic [1:0]   C_DRIVE    = 2'd1;
  localparam logic [1:0]   C_SEND     = 2'd2;
  localparam logic [1:0]   C_DONE     = 2'd3;
  localparam logic [127:0] C_SEED     = (SEED == 128'h0) ? 128'h1 : SEED;
  localparam logic [7:0]   C_SETTLE   = 8'(SETTLE);
  localparam logic [15:0]  C_LAST_IDX = 16'(NVEC - 1);

  logic [1:0]   r_state;
  logic [1:0]   w_next_state;
  logic [7:0]   r_cnt;
  logic [127:0] r_vec;
  logic [127:0] r_res_data;
  logic [127:0] r_sig;
  logic [15:0]  r_idx;
  logic         w_start_ok;
  logic         w_handshake;
  logic         w_last;

  // x^128 + x^127 + x^126 + x^121 + 1, shared by stimulus LFSR and MISR
  function automatic logic fb(input logic [127:0] x);
    return x[127] ^ x[126] ^ x[125] ^ x[120];
  endfunction

  assign w_start_ok  = start && ((r_state == C_IDLE) || (r_state == C_DONE));
  assign w_handshake = (r_state == C_SEND) && res_ready;
  assign w_last      = (r_idx == C_LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE, C_DONE: if (start) w_next_state = C_DRIVE;
      C_DRIVE:        if (r_cnt == 8'd0) w_next_state = C_SEND;
      C_SEND:         if (res_ready) w_next_state = w_last ? C_DONE : C_DRIVE;
      default:        w_next_state = C_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state == C_DRIVE) || (r_state == C_SEND);
    done      = (r_state == C_DONE);
    res_valid = (r_state == C_SEND);
  end

  // Counter is loaded with SETTLE and sampling happens once it has reached
  // zero, so dut_out is captured SETTLE+1 edges after vec_out changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= 8'd0;
      r_vec      <= 128'h0;
      r_res_data <= 128'h0;
      r_sig      <= 128'h0;
      r_idx      <= 16'd0;
    end else if (w_start_ok) begin
      r_cnt <= C_SETTLE;
      r_vec <= C_SEED;
      r_sig <= 128'h0;
      r_idx <= 16'd0;
    end else if (r_state == C_DRIVE) begin
      if (r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end else begin
        r_res_data <= dut_out;
      end
    end else if (w_handshake) begin
      r_sig <= {r_sig[126:0], fb(r_sig)} ^ r_res_data;
      if (!w_last) begin
        r_idx <= r_idx + 16'd1;
        r_vec <= {r_vec[126:0], fb(r_vec)};
        r_cnt <= C_SETTLE;
      end
    end
  end

  assign vec_out   = r_vec;
  assign res_data  = r_res_data;
  assign res_index = r_idx;
  assign signature = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_cosim_vector_driver.sv
`default_nettype none
// Directed bench: scoreboard on the main instance, direct timing/seed checks
// on two auxiliary instances with different parameters.
module tb_cosim_vector_driver;

  localparam logic [127:0] B_SEED = {1'b1, 127'h0};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         a_start, a_busy, a_done, a_valid, a_ready;
  logic [127:0] a_vec, a_data, a_sig;
  logic [15:0]  a_idx;
  logic         b_start, b_busy, b_done, b_valid, b_ready;
  logic [127:0] b_vec, b_data, b_sig;
  logic [15:0]  b_idx;
  logic         c_start, c_busy, c_done, c_valid, c_ready;
  logic [127:0] c_vec, c_data, c_sig;
  logic [15:0]  c_idx;

  cosim_vector_driver #(.SEED(128'h1), .SETTLE(1), .NVEC(3)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .busy(a_busy), .done(a_done),
    .vec_out(a_vec), .dut_out(a_vec), .res_valid(a_valid), .res_ready(a_ready),
    .res_data(a_data), .res_index(a_idx), .signature(a_sig));

  cosim_vector_driver #(.SEED(B_SEED), .SETTLE(4), .NVEC(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .busy(b_busy), .done(b_done),
    .vec_out(b_vec), .dut_out(b_vec), .res_valid(b_valid), .res_ready(b_ready),
    .res_data(b_data), .res_index(b_idx), .signature(b_sig));

  cosim_vector_driver #(.SEED(128'h0), .SETTLE(1), .NVEC(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(c_start), .busy(c_busy), .done(c_done),
    .vec_out(c_vec), .dut_out(c_vec), .res_valid(c_valid), .res_ready(c_ready),
    .res_data(c_data), .res_index(c_idx), .signature(c_sig));

  typedef struct {
    logic [127:0] data;
    logic [15:0]  idx;
    logic [127:0] sig;
  } exp_t;

  exp_t sb_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {127'h0, act}, {127'h0, exp});
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    chk(name, {112'h0, act}, {112'h0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [127:0] d, input logic [15:0] i, input logic [127:0] s);
    exp_t e;
    e.data = d;
    e.idx  = i;
    e.sig  = s;
    sb_q.push_back(e);
  endtask

  // Loopback, SEED=1: samples 1,2,4 and signatures 1,0,4
  task automatic push_full_run();
    push(128'h1, 16'd0, 128'h1);
    push(128'h2, 16'd1, 128'h0);
    push(128'h4, 16'd2, 128'h4);
  endtask

  // Monitor: every accepted sample is checked against the queue head and the
  // signature is checked on the following cycle.
  initial begin
    logic         sig_pending;
    logic [127:0] exp_sig;
    exp_t         e;
    sig_pending = 1'b0;
    exp_sig     = 128'h0;
    forever begin
      @(negedge clk);
      if (sig_pending) begin
        chk("sb_signature", a_sig, exp_sig);
        sig_pending = 1'b0;
      end
      if (reset_n && a_valid && a_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected_sample: got data %h index %0d, expected none", a_data, a_idx);
        end else begin
          e = sb_q.pop_front();
          chk("sb_res_data", a_data, e.data);
          chk16("sb_res_index", a_idx, e.idx);
          exp_sig     = e.sig;
          sig_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    a_start = 1'b0; a_ready = 1'b0;
    b_start = 1'b0; b_ready = 1'b0;
    c_start = 1'b0; c_ready = 1'b0;
    #2;
    chk("rst_vec_out", a_vec, 128'h0);
    chk("rst_res_data", a_data, 128'h0);
    chk("rst_signature", a_sig, 128'h0);
    chk16("rst_res_index", a_idx, 16'd0);
    chk1("rst_busy", a_busy, 1'b0);
    chk1("rst_done", a_done, 1'b0);
    chk1("rst_res_valid", a_valid, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Zero seed is replaced by 1
    c_ready = 1'b1;
    c_start = 1'b1; tick(); c_start = 1'b0;
    chk("c_zero_seed_vec", c_vec, 128'h1);
    for (int i = 0; i < 20 && !c_done; i++) tick();
    chk1("c_done", c_done, 1'b1);
    chk("c_signature", c_sig, 128'h1);

    // SETTLE=4 timing and MSB-only seed stepping to 1
    b_start = 1'b1; tick(); b_start = 1'b0;
    chk1("b_busy_after_start", b_busy, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk1("b_settle_valid_low", b_valid, 1'b0);
      chk("b_settle_vec_hold", b_vec, B_SEED);
    end
    tick();
    chk1("b_valid_edge5", b_valid, 1'b1);
    chk("b_first_sample", b_data, B_SEED);
    chk("b_vec_edge5", b_vec, B_SEED);
    b_ready = 1'b1; tick(); b_ready = 1'b0;
    chk("b_second_vec", b_vec, 128'h1);
    chk("b_sig_first", b_sig, B_SEED);
    chk16("b_index_1", b_idx, 16'd1);
    b_ready = 1'b1;
    for (int i = 0; i < 30 && !b_done; i++) tick();
    chk1("b_done", b_done, 1'b1);
    chk("b_sig_final", b_sig, 128'h0);
    chk1("b_busy_done", b_busy, 1'b0);

    // Run 1: full loopback, start pulsed during DRIVE must be ignored
    push_full_run();
    a_ready = 1'b1;
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 20 && a_idx != 16'd1; i++) tick();
    chk16("a_reach_index1", a_idx, 16'd1);
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 30 && !a_done; i++) tick();
    chk1("a_run1_done", a_done, 1'b1);
    chk1("a_run1_busy", a_busy, 1'b0);
    chk16("a_run1_index", a_idx, 16'd2);
    chk("a_run1_sig", a_sig, 128'h4);
    chk("a_run1_vec_hold", a_vec, 128'h4);

    // Run 2: restart from DONE with backpressure on the second sample
    push_full_run();
    a_ready = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk1("a_restart_done_low", a_done, 1'b0);
    chk1("a_restart_busy", a_busy, 1'b1);
    chk16("a_restart_index", a_idx, 16'd0);
    chk("a_restart_sig", a_sig, 128'h0);
    for (int i = 0; i < 20 && !a_valid; i++) tick();
    chk1("a_run2_valid0", a_valid, 1'b1);
    a_ready = 1'b1; tick(); a_ready = 1'b0;
    for (int i = 0; i < 20 && !a_valid; i++) tick();
    chk1("a_run2_valid1", a_valid, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk1("bp_valid", a_valid, 1'b1);
      chk("bp_res_data", a_data, 128'h2);
      chk("bp_vec_out", a_vec, 128'h2);
      chk16("bp_res_index", a_idx, 16'd1);
      chk("bp_signature", a_sig, 128'h1);
    end
    a_ready = 1'b1;
    for (int i = 0; i < 30 && !a_done; i++) tick();
    chk1("a_run2_done", a_done, 1'b1);
    chk("a_run2_sig", a_sig, 128'h4);

    // Run 3: reset asserted mid-SEND at index 1
    push(128'h1, 16'd0, 128'h1);
    a_ready = 1'b0;
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 20 && !a_valid; i++) tick();
    a_ready = 1'b1; tick(); a_ready = 1'b0;
    for (int i = 0; i < 20 && !a_valid; i++) tick();
    chk16("a_run3_index1", a_idx, 16'd1);
    tick(); tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_vec_out", a_vec, 128'h0);
    chk("abort_res_data", a_data, 128'h0);
    chk("abort_signature", a_sig, 128'h0);
    chk16("abort_res_index", a_idx, 16'd0);
    chk1("abort_busy", a_busy, 1'b0);
    chk1("abort_done", a_done, 1'b0);
    chk1("abort_res_valid", a_valid, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    chk1("abort_idle_busy", a_busy, 1'b0);

    // Run 4: replay from SEED after the abort
    push_full_run();
    a_ready = 1'b1;
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 30 && !a_done; i++) tick();
    chk1("a_run4_done", a_done, 1'b1);
    chk16("a_run4_index", a_idx, 16'd2);
    chk("a_run4_sig", a_sig, 128'h4);
    tick();
    chk("sb_drained", 128'(sb_q.size()), 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
